// File: rtl/dmadd_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : dmadd_sequencer                                           |
// | Brief    : Byte-command sequencer driving DMADD init/load/run cycles |
// | Revision : 1.0                                                       |
// +----------------------------------------------------------------------+
module dmadd_sequencer #(
  parameter int RUN_TIMEOUT = 20
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [7:0] cmd_data,
  output logic       res_valid,
  input  logic       res_ready,
  output logic [7:0] res_data,
  output logic       res_timeout,
  output logic       busy,
  output logic [3:0] dm_index,
  output logic [3:0] dm_data,
  output logic [1:0] dm_insn,
  output logic       dm_load,
  output logic       dm_run,
  input  logic [7:0] dm_out,
  input  logic [3:0] dm_step
);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_INIT_CYC = 3'd1,
    S_GET_DATA = 3'd2,
    S_LOAD_CYC = 3'd3,
    S_RUN      = 3'd4,
    S_RESULT   = 3'd5
  } state_t;

  localparam logic [1:0] c_op_init = 2'b00;
  localparam logic [1:0] c_op_load = 2'b01;
  localparam logic [1:0] c_op_run  = 2'b10;
  localparam logic [7:0] c_timeout = 8'(RUN_TIMEOUT);

  state_t     r_state;
  state_t     w_next_state;
  logic [1:0] r_mode;
  logic [3:0] r_index;
  logic [3:0] r_data;
  logic [7:0] r_cnt;
  logic [7:0] r_res_data;
  logic       r_res_timeout;

  logic       w_cmd_fire;
  logic [1:0] w_opcode;
  logic       w_run_done;
  logic       w_run_expired;
  logic       w_unused;

  assign w_opcode = cmd_data[7:6];
  assign w_cmd_fire = cmd_valid && cmd_ready;
  // A zero counter marks the first RUN cycle, where dm_step is still stale.
  assign w_run_done = (r_cnt != 8'd0) && (dm_step == 4'd0);
  assign w_run_expired = (r_cnt == c_timeout);
  assign w_unused = ^cmd_data[5:4];

  assign dm_index    = r_index;
  assign dm_data     = r_data;
  assign dm_insn     = r_mode;
  assign res_data    = r_res_data;
  assign res_timeout = r_res_timeout;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    cmd_ready    = 1'b0;
    busy         = 1'b1;
    dm_load      = 1'b0;
    dm_run       = 1'b0;
    res_valid    = 1'b0;
    case (r_state)
      S_IDLE: begin
        cmd_ready = 1'b1;
        busy      = 1'b0;
        if (w_cmd_fire) begin
          case (w_opcode)
            c_op_init: w_next_state = S_INIT_CYC;
            c_op_load: w_next_state = S_GET_DATA;
            c_op_run:  w_next_state = S_RUN;
            default:   w_next_state = S_IDLE;
          endcase
        end
      end
      S_INIT_CYC: w_next_state = S_IDLE;
      S_GET_DATA: begin
        cmd_ready = 1'b1;
        if (w_cmd_fire) begin
          w_next_state = S_LOAD_CYC;
        end
      end
      S_LOAD_CYC: begin
        dm_load      = 1'b1;
        w_next_state = S_IDLE;
      end
      S_RUN: begin
        dm_run = 1'b1;
        if (w_run_done || w_run_expired) begin
          w_next_state = S_RESULT;
        end
      end
      S_RESULT: begin
        res_valid = 1'b1;
        if (res_ready) begin
          w_next_state = S_IDLE;
        end
      end
      default: w_next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_mode        <= 2'b00;
      r_index       <= 4'd0;
      r_data        <= 4'd0;
      r_cnt         <= 8'd0;
      r_res_data    <= 8'd0;
      r_res_timeout <= 1'b0;
    end else begin
      if ((r_state == S_IDLE) && w_cmd_fire) begin
        case (w_opcode)
          c_op_init: r_mode  <= cmd_data[1:0];
          c_op_load: r_index <= cmd_data[3:0];
          c_op_run:  r_cnt   <= 8'd0;
          default:   ;
        endcase
      end
      if ((r_state == S_GET_DATA) && w_cmd_fire) begin
        r_data <= cmd_data[3:0];
      end
      if (r_state == S_RUN) begin
        if (r_cnt != 8'hFF) begin
          r_cnt <= r_cnt + 8'd1;
        end
        // Completion is tested first so it wins over a coincident timeout.
        if (w_run_done) begin
          r_res_data    <= dm_out;
          r_res_timeout <= 1'b0;
        end else if (w_run_expired) begin
          r_res_data    <= dm_out;
          r_res_timeout <= 1'b1;
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_dmadd_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : tb_dmadd_sequencer                                        |
// | Brief    : Directed plus randomized bench with a DMADD engine stub   |
// | Revision : 1.0                                                       |
// +----------------------------------------------------------------------+
module tb_dmadd_sequencer;

  localparam int RUN_TIMEOUT = 20;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic [7:0] cmd_data = 8'h00;
  logic       res_valid;
  logic       res_ready = 1'b0;
  logic [7:0] res_data;
  logic       res_timeout;
  logic       busy;
  logic [3:0] dm_index;
  logic [3:0] dm_data;
  logic [1:0] dm_insn;
  logic       dm_load;
  logic       dm_run;
  logic [7:0] dm_out;
  logic [3:0] dm_step;

  int errors = 0;
  int checks = 0;

  // Engine stub: step reaches zero after eng_steps run cycles; out carries
  // the last loaded index when done, else a marker with the run-cycle count.
  int         eng_steps = 0;
  int         eng_cnt = 0;
  logic [3:0] eng_idx = 4'd0;
  logic [3:0] eng_hi = 4'd0;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (dm_load) eng_idx <= dm_index;
    if (dm_run) eng_cnt <= eng_cnt + 1;
    else eng_cnt <= 0;
  end

  assign dm_step = (!dm_run || eng_cnt >= eng_steps) ? 4'h0 : 4'h7;
  assign dm_out  = (dm_step == 4'h0) ? {eng_hi, eng_idx} : (8'h80 | 8'(eng_cnt));

  dmadd_sequencer #(.RUN_TIMEOUT(RUN_TIMEOUT)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_data(cmd_data),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
    .res_timeout(res_timeout), .busy(busy),
    .dm_index(dm_index), .dm_data(dm_data), .dm_insn(dm_insn),
    .dm_load(dm_load), .dm_run(dm_run), .dm_out(dm_out), .dm_step(dm_step)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_cmd_ready"}, cmd_ready, 1);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_res_valid"}, res_valid, 0);
    chk({tag, "_dm_load"}, dm_load, 0);
    chk({tag, "_dm_run"}, dm_run, 0);
    chk({tag, "_dm_insn"}, dm_insn, 0);
    chk({tag, "_res_data"}, {res_timeout, res_data}, 0);
    chk({tag, "_dm_idx_data"}, {dm_index, dm_data}, 0);
  endtask

  // Presents one byte and returns #1 after the edge that transferred it.
  task automatic send(input logic [7:0] b);
    int n;
    n = 0;
    cmd_valid = 1'b1;
    cmd_data  = b;
    @(negedge clk);
    while (!cmd_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("send_ready", cmd_ready, 1);
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
  endtask

  task automatic pulse_reset();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
  endtask

  // Issues RUN and checks run length, captured result and backpressure.
  task automatic do_run(input string tag, input int steps, input logic [1:0] mode,
                        input logic [3:0] idx, input logic [3:0] hi, input int bp);
    int k_done, k_exp, runs, n;
    logic [7:0] exp_data;
    logic exp_to;
    eng_steps = steps;
    eng_hi    = hi;
    k_done = (steps < 1) ? 1 : steps;
    if (k_done <= RUN_TIMEOUT) begin
      k_exp = k_done; exp_data = {hi, idx}; exp_to = 1'b0;
    end else begin
      k_exp = RUN_TIMEOUT; exp_data = 8'h80 | 8'(RUN_TIMEOUT); exp_to = 1'b1;
    end
    send(8'h80);
    chk({tag, "_run_first"}, {dm_run, dm_load, dm_insn}, {1'b1, 1'b0, mode});
    runs = 0;
    n = 0;
    while (!res_valid && n < 300) begin
      if (dm_run) runs++;
      n++;
      tick();
    end
    chk({tag, "_run_cycles"}, runs, k_exp + 1);
    chk({tag, "_res_valid"}, res_valid, 1);
    chk({tag, "_res_data"}, res_data, exp_data);
    chk({tag, "_res_timeout"}, res_timeout, exp_to);
    chk({tag, "_res_pins"}, {dm_run, cmd_ready, busy}, 3'b001);
    for (int i = 0; i < bp; i++) begin
      tick();
      chk({tag, "_hold"}, {res_valid, cmd_ready, res_timeout, res_data}, {1'b1, 1'b0, exp_to, exp_data});
    end
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    chk({tag, "_after_ack"}, {res_valid, cmd_ready, busy}, 3'b010);
  endtask

  initial begin
    logic [1:0] mode;
    logic [3:0] idx, dat;
    logic [1:0] junk;

    // Reset values
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    chk_reset_outputs("reset");

    // Load pin timing in min mode
    send(8'h00);
    chk("init_cycle", {dm_run, dm_load, dm_insn, busy}, 5'b00001);
    send(8'h45);
    chk("getdata_ready", {cmd_ready, busy, dm_load}, 3'b110);
    send(8'h03);
    chk("load_cycle", {dm_load, dm_run, dm_index, dm_data, dm_insn}, {2'b10, 4'd5, 4'd3, 2'b00});
    tick();
    chk("load_one_cycle", {dm_load, busy, cmd_ready}, 3'b001);

    // Completion in min mode
    send(8'h00);
    send(8'h45);
    send(8'h01);
    do_run("complete", 3, 2'b00, 4'd5, 4'd0, 0);

    // Timeout with engine stuck
    send(8'h01);
    do_run("timeout", 1000, 2'b01, 4'd5, 4'd0, 0);

    // Completion exactly at the timeout boundary wins
    do_run("coincide", RUN_TIMEOUT, 2'b01, 4'd5, 4'd9, 0);

    // Result backpressure
    do_run("backpressure", 2, 2'b01, 4'd5, 4'd3, 10);

    // Reset during RUN
    send(8'h02);
    eng_steps = 1000;
    send(8'h80);
    tick();
    tick();
    chk("mid_run_active", dm_run, 1);
    pulse_reset();
    chk_reset_outputs("rst_run");

    // Reset during GET_DATA
    send(8'h03);
    send(8'h4A);
    chk("in_getdata", {busy, cmd_ready}, 2'b11);
    pulse_reset();
    chk_reset_outputs("rst_getdata");

    // NOP after reset does nothing
    send(8'hC0);
    chk_reset_outputs("nop");
    tick();
    chk_reset_outputs("nop_next");

    // Randomized command sequences
    for (int it = 0; it < 12; it++) begin
      mode = 2'($urandom_range(0, 3));
      idx  = 4'($urandom_range(0, 15));
      dat  = 4'($urandom_range(0, 15));
      junk = 2'($urandom_range(0, 3));
      send({4'b0000, junk, mode});
      chk("rnd_init", {dm_insn, dm_load, dm_run, busy}, {mode, 3'b001});
      send({2'b11, junk, 4'($urandom_range(0, 15))});
      chk("rnd_nop", {busy, dm_insn}, {1'b0, mode});
      send({2'b01, junk, idx});
      send({junk, junk, dat});
      chk("rnd_load", {dm_load, dm_index, dm_data, dm_insn}, {1'b1, idx, dat, mode});
      do_run("rnd", $urandom_range(0, RUN_TIMEOUT + 5), mode, idx,
             4'($urandom_range(0, 15)), $urandom_range(0, 4));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, observed=running expected=finished");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire

// File: doc/dmadd_sequencer.md
Name: dmadd_sequencer

Overview:
- Command-side driver for the DMADD delta/scan engine. It takes a byte command stream over a valid/ready handshake and turns it into DMADD init, load and run cycles on the engine's index/data/insn/load/run pins.
- It monitors the engine's step output to detect completion, captures the 8-bit engine result and returns it over a result valid/ready handshake.
- It sits between the tile's input pins or host interface and one DMADD instance.

Parameters:
- RUN_TIMEOUT, 20, maximum run cycles before the sequencer aborts the run and returns a timeout result (legal range 1..255).

Ports:
- clk  input  1  system clock
- rst_n  input  1  reset_n - low to reset; synchronous, active-low
- cmd_valid  input  1  command byte valid
- cmd_ready  output  1  sequencer accepts a command byte this cycle
- cmd_data  input  8  command byte; [7:6] opcode, [5:0] operand
- res_valid  output  1  result available
- res_ready  input  1  result consumer ready
- res_data  output  8  captured engine result
- res_timeout  output  1  result was produced by timeout, not by engine completion
- busy  output  1  sequencer is not in IDLE
- dm_index  output  4  to DMADD index
- dm_data  output  4  to DMADD data
- dm_insn  output  2  to DMADD insn (holds the current mode)
- dm_load  output  1  to DMADD load
- dm_run  output  1  to DMADD run
- dm_out  input  8  from DMADD out
- dm_step  input  4  from DMADD out_top; the step value, where 0 means the engine is done

Behaviour:
- Reset (rst_n=0 at a clock edge): state=IDLE, mode=2'b00, all outputs 0 except cmd_ready. Run counter=0, captured result=0. Reset takes priority over everything, including mid-run, mid-LOAD and a pending result; any pending result is discarded.
- Command handshake: a byte transfers when cmd_valid&&cmd_ready at the clock edge. cmd_ready=1 only in IDLE and GET_DATA.
- Opcodes:
  - 00 INIT: mode<=cmd_data[1:0]; next cycle issues one init cycle (dm_run=0, dm_load=0, dm_insn=new mode).
  - 01 LOAD: index<=cmd_data[3:0]; enter GET_DATA. The next accepted byte supplies data=cmd_data[3:0]; its opcode bits are ignored.
  - 10 RUN: enter RUN.
  - 11 NOP: accepted, no state change, no pins toggled.
- States:
  - IDLE: dm_load=0, dm_run=0, dm_insn=mode.
  - INIT_CYC: one cycle, then back to IDLE.
  - GET_DATA: waits indefinitely for the data byte; busy=1.
  - LOAD_CYC: exactly one cycle with dm_load=1, dm_run=0, dm_index=index, dm_data=data, dm_insn=mode. Begins the cycle after the data byte is accepted; returns to IDLE.
  - RUN:
    - dm_run=1, dm_load=0, dm_insn=mode from the cycle after the RUN byte is accepted. The run counter increments each RUN cycle.
    - From the second RUN cycle on, if dm_step==0, capture res_data<=dm_out, res_timeout<=0, go to RESULT. dm_step is ignored in the first RUN cycle because its value is stale from init.
    - Otherwise, if counter==RUN_TIMEOUT, capture res_data<=dm_out, res_timeout<=1, go to RESULT.
    - If done and timeout coincide, completion wins (res_timeout=0).
  - RESULT: dm_run=0, res_valid=1; res_data and res_timeout are held stable until res_valid&&res_ready, then IDLE. cmd_ready=0 throughout, which gives full backpressure.
- Latency:
  - INIT/LOAD pin activity appears 1 cycle after the byte is accepted.
  - The result is registered, so res_valid rises the cycle after done is sampled.
  - Minimum command-to-result latency is 3 cycles.
- Widths: the run counter is 8 bits and saturates; it clears on every RUN entry. dm_index and dm_data pass through unmodified. There is no arithmetic on data.
- busy = (state != IDLE).

Test Plan:
- Reset values: hold rst_n=0 for 2 cycles -> cmd_ready=1; res_valid, busy, dm_load, dm_run=0; dm_insn=00.
- Load pin timing: bytes 0x00 (INIT min), 0x45, 0x03 -> exactly one cycle with dm_load=1, dm_index=5, dm_data=3, dm_insn=00, one cycle after 0x03 is accepted. cmd_ready stays 1 between the two LOAD bytes.
- Completion, min mode: INIT 0x00, LOAD 0x45/0x01, RUN 0x80 with a DMADD instance attached -> dm_run asserted until dm_step==0; res_valid=1, res_data=0x05, res_timeout=0.
- Timeout: INIT 0x01 with no loads, RUN 0x80, model holds dm_step=4'hF -> res_valid exactly RUN_TIMEOUT+1 cycles after the run starts; res_timeout=1, dm_run=0.
- Result backpressure: hold res_ready=0 for 10 cycles after a result -> res_valid and res_data stable, cmd_ready=0. Then res_ready=1 for one cycle -> IDLE and cmd_ready=1.
- Reset mid-operation: assert rst_n=0 during RUN and, separately, in GET_DATA -> next cycle all outputs are at reset values. A subsequent NOP 0xC0 is accepted and produces no pin activity.
